// File: rtl/shift_issue_unit.sv
// shift_issue_unit: handshaked EX-stage shift sequencer feeding one barrel_shifter32.
//   SLL/SRL/SRA complete in one shifter pass; ROTR takes two passes through the
//   same shifter (SRL by s, then SLL by -s, OR'd together).
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   flush                 synchronous squash of the in-flight op
//   in_valid/in_ready     request handshake (in_ready = state is IDLE)
//   op, variable, shamt   op code, amount select (rs[4:0] vs shamt), immediate amount
//   rs, rt, tag           amount source, value to shift, destination tag
//   out_valid/out_ready   result handshake toward writeback
//   result, out_tag       registered shifted value and its tag
//   out_err               reserved-op flag, qualified by out_valid

module barrel_shifter32 (
  input  logic [31:0] data_in,
  input  logic [4:0]  amount,
  input  logic        direction,   // 0 = left, 1 = right
  input  logic        arithmetic,  // sign fill on right shifts
  output logic [31:0] data_out
);
  logic [5:0][31:0] stg;
  logic [31:0]      rev_in, rev_out;
  logic             fill;

  assign fill = direction & arithmetic & data_in[31];

  // Left shifts reuse the right-shift network on bit-reversed data.
  for (genvar b = 0; b < 32; b++) begin : g_rev
    assign rev_in[b]  = data_in[31-b];
    assign rev_out[b] = stg[5][31-b];
  end

  assign stg[0] = direction ? data_in : rev_in;

  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stg[k+1] = amount[k] ? {{SH{fill}}, stg[k][31:SH]} : stg[k];
  end

  assign data_out = direction ? stg[5] : rev_out;
endmodule

module shift_issue_unit #(
  parameter int WIDTH  = 32,
  parameter bit ROT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             variable,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [4:0]       tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       out_tag,
  output logic             out_err
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rt_q, rt_d, partial_q, partial_d, result_q, result_d;
  logic [4:0]       amt_q, amt_d, tag_q, tag_d, out_tag_q, out_tag_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d, out_err_q, out_err_d;

  logic             sh_dir, sh_arith;
  logic [4:0]       sh_amt;
  logic [31:0]      sh_out;
  logic             op_rot, op_rsvd;

  // Only amount bits of rs are meaningful.
  logic unused_rs;
  assign unused_rs = ^rs[WIDTH-1:5];

  assign op_rot  = ROT_EN && (op_q == 3'b011);
  assign op_rsvd = op_q[2] || (!ROT_EN && (op_q == 3'b011));

  // Shifter is driven purely from registered operands.
  always_comb begin
    sh_dir   = 1'b0;
    sh_arith = 1'b0;
    sh_amt   = amt_q;
    if (state_q == S_EXEC2) begin
      // second rotate pass: SLL by (32 - s) mod 32; s=0 gives rt | rt = rt
      sh_amt = 5'd0 - amt_q;
    end else begin
      case (op_q[1:0])
        2'b01:   sh_dir = 1'b1;
        2'b10: begin sh_dir = 1'b1; sh_arith = 1'b1; end
        2'b11:   sh_dir = 1'b1;
        default: ;
      endcase
    end
  end

  barrel_shifter32 u_shifter (
    .data_in    (rt_q),
    .amount     (sh_amt),
    .direction  (sh_dir),
    .arithmetic (sh_arith),
    .data_out   (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    rt_d        = rt_q;
    amt_d       = amt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    partial_d   = partial_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        rt_d    = rt;
        amt_d   = variable ? rs[4:0] : shamt;
        op_d    = op;
        tag_d   = tag;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (op_rot) begin
          partial_d = sh_out;
          state_d   = S_EXEC2;
        end else begin
          result_d    = op_rsvd ? '0 : sh_out;
          out_err_d   = op_rsvd;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_EXEC2: begin
        result_d    = sh_out | partial_q;
        out_err_d   = 1'b0;
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Squash wins over accept and over any in-flight progress.
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
      if (state_q == S_IDLE) begin
        rt_d  = rt_q;
        amt_d = amt_q;
        op_d  = op_q;
        tag_d = tag_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rt_q        <= '0;
      amt_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      partial_q   <= '0;
      result_q    <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rt_q        <= rt_d;
      amt_q       <= amt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      partial_q   <= partial_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
endmodule

// File: tb/tb_shift_issue_unit.sv
// Scoreboard bench for shift_issue_unit: expected results are queued at
// request time and compared when the output handshake completes.
module tb_shift_issue_unit;
  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, variable, out_valid, out_ready, out_err;
  logic [2:0]  op;
  logic [4:0]  shamt, tag, out_tag;
  logic [31:0] rs, rt, result;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tg;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  shift_issue_unit #(.WIDTH(32), .ROT_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .variable(variable), .shamt(shamt), .rs(rs), .rt(rt), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model, written independently of the shifter structure.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [4:0] s);
    case (o)
      3'b000:  return x << s;
      3'b001:  return x >> s;
      3'b010:  return $unsigned($signed(x) >>> s);
      3'b011:  return (s == 5'd0) ? x : ((x >> s) | (x << (6'd32 - {1'b0, s})));
      default: return 32'h0;
    endcase
  endfunction

  // Output monitor: pops on every completed output handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("out_tag", 32'(out_tag), 32'(e.tg));
        chk("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(posedge clock); #1;
    while (!in_ready && w < 20) begin @(posedge clock); #1; w++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Issue one op, queue its expectation, and check accept-to-out_valid latency.
  task automatic send(input logic [2:0] o, input logic v, input logic [4:0] sa,
                      input logic [31:0] rsv, input logic [31:0] rtv, input logic [4:0] tg,
                      input logic [31:0] er, input logic ee, input int el);
    int lat;
    exp_t e;
    wait_idle();
    op = o; variable = v; shamt = sa; rs = rsv; rt = rtv; tag = tg; in_valid = 1'b1;
    e.res = er; e.tg = tg; e.err = ee;
    exp_q.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0; rt = $urandom; rs = $urandom; shamt = 5'($urandom); op = 3'($urandom);
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 8) begin @(negedge clock); lat++; end
    chk("latency", 32'(lat), 32'(el));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; variable = 1'b0; shamt = '0; rs = '0; rt = '0; tag = '0;
    #23;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send(3'b010, 1'b0, 5'd4, 32'h0, 32'h8000_00F0, 5'd1, 32'hF800_000F, 1'b0, 2);
    send(3'b000, 1'b1, 5'd0, 32'h0000_0023, 32'h0000_0001, 5'd7, 32'h0000_0008, 1'b0, 2);
    send(3'b001, 1'b0, 5'd31, 32'h0, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 1'b0, 2);
    send(3'b011, 1'b0, 5'd8, 32'h0, 32'h1234_5678, 5'd3, 32'h7812_3456, 1'b0, 3);
    send(3'b011, 1'b0, 5'd0, 32'h0, 32'h1234_5678, 5'd4, 32'h1234_5678, 1'b0, 3);
    send(3'b100, 1'b0, 5'd3, 32'h0, 32'hDEAD_BEEF, 5'd5, 32'h0, 1'b1, 2);
    send(3'b000, 1'b0, 5'd0, 32'h0, 32'hCAFE_F00D, 5'd6, 32'hCAFE_F00D, 1'b0, 2);

    // Backpressure: result held, in_valid pulses ignored.
    @(posedge clock); #1 out_ready = 1'b0;
    send(3'b000, 1'b0, 5'd4, 32'h0, 32'h0000_0ABC, 5'd9, 32'h0000_ABC0, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      in_valid = i[0]; op = 3'b001; shamt = 5'd1; rt = 32'hFFFF_0000; tag = 5'd30;
      @(negedge clock);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'h0000_ABC0);
      chk("bp_out_tag", 32'(out_tag), 32'd9);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Flush during EXEC2 of a rotate: nothing queued, nothing may come out.
    wait_idle();
    op = 3'b011; variable = 1'b0; shamt = 5'd12; rt = 32'hA5A5_0F0F; tag = 5'd11; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;   // EXEC1
    @(posedge clock); #1 flush = 1'b1;      // EXEC2
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    send(3'b000, 1'b0, 5'd1, 32'h0, 32'h4000_0000, 5'd12, 32'h8000_0000, 1'b0, 2);

    // Flush together with a request: nothing accepted.
    wait_idle();
    op = 3'b000; shamt = 5'd2; rt = 32'h1; tag = 5'd13; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_accept_in_ready", 32'(in_ready), 32'd1);

    // Async reset during EXEC1.
    wait_idle();
    op = 3'b001; variable = 1'b0; shamt = 5'd2; rt = 32'hF000_0000; tag = 5'd14; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clock); #3 reset_n = 1'b1;
    @(negedge clock);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_no_output", 32'(out_valid), 32'd0);
    send(3'b010, 1'b1, 5'd0, 32'hFFFF_FFE1, 32'h8000_0000, 5'd15, 32'hC000_0000, 1'b0, 2);

    // Random ops against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  ro;
      logic        rv;
      logic [4:0]  rsa;
      logic [31:0] rrs, rrt;
      ro  = 3'($urandom_range(0, 4));
      rv  = 1'($urandom);
      rsa = 5'($urandom);
      rrs = $urandom;
      rrt = $urandom;
      send(ro, rv, rsa, rrs, rrt, 5'(i),
           model(ro, rrt, rv ? rrs[4:0] : rsa), ro[2], (ro == 3'b011) ? 3 : 2);
    end

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
